// File: rtl/cas_fsk_player.sv
// CAS image to MSX 1200-baud FSK player: fetches 8-byte groups from the cassette buffer,
// replaces sync groups with header tone and frames every other byte. Optional: CAS_SILENCE_EN.
module cas_fsk_player #(
    parameter int HALF_1200     = 2238,
    parameter int HALF_2400     = 1119,
    parameter int LONG_HDR      = 16000,
    parameter int SHORT_HDR     = 4000,
    parameter int SILENCE_TICKS = 5369318
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_5m3,
    input  logic        play,
    input  logic        rewind,
    input  logic [26:0] cas_size,
    output logic [26:0] ram_a,
    output logic        ram_rd,
    input  logic [7:0]  ram_di,
    input  logic        ram_ready,
    output logic        cas_out,
    output logic        eof,
    output logic        busy
);

    // The tick counter is sized for the longest interval it may time.
    localparam int TICK_MAX = (SILENCE_TICKS > HALF_1200) ? SILENCE_TICKS : HALF_1200;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [TICK_W-1:0] H12_M1 = TICK_W'(HALF_1200 - 1);
    localparam logic [TICK_W-1:0] H24_M1 = TICK_W'(HALF_2400 - 1);
    localparam logic [15:0]       LNG_M1 = 16'(LONG_HDR - 1);
    localparam logic [15:0]       SHT_M1 = 16'(SHORT_HDR - 1);
`ifdef CAS_SILENCE_EN
    localparam logic [TICK_W-1:0] SIL_M1 = TICK_W'(SILENCE_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_PEEK, S_SILENCE, S_HEADER, S_DATA
    } state_t;

    function automatic logic sync_match(input logic [63:0] g);
        return g == 64'h1FA6_DEBA_CC13_7D74;
    endfunction

    function automatic logic lead_is_long(input logic [7:0] b);
        return (b == 8'hD3) || (b == 8'hEA) || (b == 8'hD0);
    endfunction

    state_t              state_r, state_n;
    logic [26:0]         gp_r, gp_n;
    logic [26:0]         addr_r, addr_n;
    logic                rd_r, rd_n;
    logic [3:0]          idx_r, idx_n;
    logic [3:0]          cnt_r, cnt_n;
    logic [2:0]          byte_r, byte_n;
    logic [3:0]          bit_r, bit_n;
    logic [1:0]          ph_r, ph_n;
    logic [TICK_W-1:0]   tick_r, tick_n;
    logic [15:0]         hdr_r, hdr_n;
    logic                long_r, long_n;
    logic                cas_r, cas_n;
    logic                eof_r, eof_n;
    logic                busy_r, busy_n;
    logic [7:0]          grp_r [8];

    logic                cap_s;
    logic                run_s;
    logic                fetch_end_s;
    logic                peek_end_s;
    logic [63:0]         grp_flat_s;
    logic [7:0]          cur_byte_s;
    logic [2:0]          bit_sel_s;
    logic                bit_val_s;
    logic                half_last_s;
    logic                ph_last_s;

    assign run_s       = ce_5m3 & play;
    assign fetch_end_s = ({1'b0, gp_r} + {24'd0, idx_r}) >= {1'b0, cas_size};
    assign peek_end_s  = ({1'b0, gp_r} + 28'd8) >= {1'b0, cas_size};
    assign grp_flat_s  = {grp_r[0], grp_r[1], grp_r[2], grp_r[3],
                          grp_r[4], grp_r[5], grp_r[6], grp_r[7]};
    assign cur_byte_s  = grp_r[byte_r];
    // Frame bits 1..8 carry d0..d7; bit 8 wraps the 3-bit selector to 7.
    assign bit_sel_s   = bit_r[2:0] - 3'd1;

    // Current frame bit value and its half-period / half-count limits.
    always_comb begin
        bit_val_s = 1'b1;
        case (bit_r)
            4'd0:        bit_val_s = 1'b0;
            4'd9, 4'd10: bit_val_s = 1'b1;
            default:     bit_val_s = cur_byte_s[bit_sel_s];
        endcase
        if (bit_val_s) begin
            half_last_s = (tick_r == H24_M1);
            ph_last_s   = (ph_r == 2'd3);
        end else begin
            half_last_s = (tick_r == H12_M1);
            ph_last_s   = (ph_r == 2'd1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        gp_n    = gp_r;
        addr_n  = addr_r;
        rd_n    = rd_r;
        idx_n   = idx_r;
        cnt_n   = cnt_r;
        byte_n  = byte_r;
        bit_n   = bit_r;
        ph_n    = ph_r;
        tick_n  = tick_r;
        hdr_n   = hdr_r;
        long_n  = long_r;
        cas_n   = cas_r;
        eof_n   = eof_r;
        busy_n  = busy_r;
        cap_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                busy_n = 1'b0;
                cas_n  = 1'b0;
                if (gp_r >= cas_size) begin
                    eof_n = 1'b1;
                end else if (play) begin
                    state_n = S_FETCH;
                    idx_n   = 4'd0;
                end else begin
                    idx_n = idx_r;
                end
            end
            S_FETCH: begin
                if (rd_r) begin
                    if (ram_ready) begin
                        cap_s = 1'b1;
                        rd_n  = 1'b0;
                        idx_n = idx_r + 4'd1;
                    end else begin
                        rd_n = 1'b1;
                    end
                end else if ((idx_r == 4'd8) || fetch_end_s) begin
                    state_n = S_CHECK;
                    cnt_n   = idx_r;
                end else if (play) begin
                    rd_n   = 1'b1;
                    addr_n = gp_r + {23'd0, idx_r};
                end else begin
                    rd_n = 1'b0;
                end
            end
            S_CHECK: begin
                if (!play) begin
                    state_n = S_CHECK;
                end else if ((cnt_r == 4'd8) && sync_match(grp_flat_s)) begin
                    state_n = S_PEEK;
                    idx_n   = 4'd0;
                end else begin
                    state_n = S_DATA;
                    byte_n  = 3'd0;
                    bit_n   = 4'd0;
                    ph_n    = 2'd0;
                    tick_n  = {TICK_W{1'b0}};
                    cas_n   = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            S_PEEK: begin
                // idx_r doubles as the "lead byte known" flag here.
                if (rd_r) begin
                    if (ram_ready) begin
                        rd_n   = 1'b0;
                        idx_n  = 4'd1;
                        long_n = lead_is_long(ram_di);
                    end else begin
                        rd_n = 1'b1;
                    end
                end else if ((idx_r == 4'd0) && peek_end_s) begin
                    idx_n  = 4'd1;
                    long_n = 1'b0;
                end else if (idx_r == 4'd0) begin
                    if (play) begin
                        rd_n   = 1'b1;
                        addr_n = gp_r + 27'd8;
                    end else begin
                        rd_n = 1'b0;
                    end
                end else if (play) begin
                    tick_n = {TICK_W{1'b0}};
                    ph_n   = 2'd0;
                    hdr_n  = 16'd0;
                    busy_n = 1'b1;
`ifdef CAS_SILENCE_EN
                    if (long_r) begin
                        state_n = S_SILENCE;
                        cas_n   = 1'b0;
                    end else begin
                        state_n = S_HEADER;
                        cas_n   = 1'b1;
                    end
`else
                    state_n = S_HEADER;
                    cas_n   = 1'b1;
`endif
                end else begin
                    state_n = S_PEEK;
                end
            end
            S_SILENCE: begin
`ifdef CAS_SILENCE_EN
                if (!run_s) begin
                    tick_n = tick_r;
                end else if (tick_r == SIL_M1) begin
                    state_n = S_HEADER;
                    tick_n  = {TICK_W{1'b0}};
                    ph_n    = 2'd0;
                    hdr_n   = 16'd0;
                    cas_n   = 1'b1;
                end else begin
                    tick_n = tick_r + TICK_W'(1);
                end
`else
                state_n = S_HEADER;
                cas_n   = 1'b1;
`endif
            end
            S_HEADER: begin
                if (!run_s) begin
                    tick_n = tick_r;
                end else if (tick_r != H24_M1) begin
                    tick_n = tick_r + TICK_W'(1);
                end else begin
                    tick_n = {TICK_W{1'b0}};
                    if (ph_r == 2'd0) begin
                        ph_n  = 2'd1;
                        cas_n = 1'b0;
                    end else if (hdr_r == (long_r ? LNG_M1 : SHT_M1)) begin
                        state_n = S_IDLE;
                        gp_n    = gp_r + 27'd8;
                        busy_n  = 1'b0;
                        cas_n   = 1'b0;
                    end else begin
                        hdr_n = hdr_r + 16'd1;
                        ph_n  = 2'd0;
                        cas_n = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!run_s) begin
                    tick_n = tick_r;
                end else if (!half_last_s) begin
                    tick_n = tick_r + TICK_W'(1);
                end else begin
                    tick_n = {TICK_W{1'b0}};
                    if (!ph_last_s) begin
                        ph_n  = ph_r + 2'd1;
                        cas_n = ~cas_r;
                    end else if (bit_r != 4'd10) begin
                        bit_n = bit_r + 4'd1;
                        ph_n  = 2'd0;
                        cas_n = 1'b1;
                    end else if ({1'b0, byte_r} == (cnt_r - 4'd1)) begin
                        state_n = S_IDLE;
                        gp_n    = gp_r + 27'd8;
                        busy_n  = 1'b0;
                        cas_n   = 1'b0;
                    end else begin
                        byte_n = byte_r + 3'd1;
                        bit_n  = 4'd0;
                        ph_n   = 2'd0;
                        cas_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                rd_n    = 1'b0;
                cas_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers; rewind restarts playback like reset.
    always_ff @(posedge clk) begin
        if (reset || rewind) begin
            state_r <= S_IDLE;
            gp_r    <= 27'd0;
            addr_r  <= 27'd0;
            rd_r    <= 1'b0;
            idx_r   <= 4'd0;
            cnt_r   <= 4'd0;
            byte_r  <= 3'd0;
            bit_r   <= 4'd0;
            ph_r    <= 2'd0;
            tick_r  <= {TICK_W{1'b0}};
            hdr_r   <= 16'd0;
            long_r  <= 1'b0;
            cas_r   <= 1'b0;
            eof_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            gp_r    <= gp_n;
            addr_r  <= addr_n;
            rd_r    <= rd_n;
            idx_r   <= idx_n;
            cnt_r   <= cnt_n;
            byte_r  <= byte_n;
            bit_r   <= bit_n;
            ph_r    <= ph_n;
            tick_r  <= tick_n;
            hdr_r   <= hdr_n;
            long_r  <= long_n;
            cas_r   <= cas_n;
            eof_r   <= eof_n;
            busy_r  <= busy_n;
        end
    end

    // Group buffer capture on a completed fetch read.
    always_ff @(posedge clk) begin
        if (cap_s) begin
            grp_r[idx_r[2:0]] <= ram_di;
        end
    end

    assign ram_a   = addr_r;
    assign ram_rd  = rd_r;
    assign cas_out = cas_r;
    assign eof     = eof_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player with shortened timing; the cas_out stream sampled on
// every advancing ce tick while busy is compared against a bench-built ideal waveform.
module tb_cas_fsk_player;

    localparam int H12 = 4;
    localparam int H24 = 2;
    localparam int LH  = 16;
    localparam int SH  = 4;
    localparam int SIL = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_5m3;
    logic        play = 1'b0;
    logic        rewind = 1'b0;
    logic [26:0] cas_size = 27'd8;
    logic [26:0] ram_a;
    logic        ram_rd;
    logic [7:0]  ram_di;
    logic        ram_ready;
    logic        cas_out;
    logic        eof;
    logic        busy;

    logic [7:0]  mem [0:63];
    logic [7:0]  sync_pat [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
    logic        wave [$];
    logic        exp_q [$];
    int          wave_base = 0;
    int          n_total = 0;
    int          n_bad = 0;
    int          addr_bad = 0;
    int          rd_cnt = 0;
    int          dly_mode = 0;
    logic        mem_hold = 1'b0;
    logic        inject_ready = 1'b0;

    cas_fsk_player #(
        .HALF_1200(H12), .HALF_2400(H24), .LONG_HDR(LH), .SHORT_HDR(SH), .SILENCE_TICKS(SIL)
    ) dut (
        .clk(clk), .reset(reset), .ce_5m3(ce_5m3), .play(play), .rewind(rewind),
        .cas_size(cas_size), .ram_a(ram_a), .ram_rd(ram_rd), .ram_di(ram_di),
        .ram_ready(ram_ready), .cas_out(cas_out), .eof(eof), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // ce toggles every cycle; record cas_out whenever the DUT will advance on the next edge.
    initial begin
        ce_5m3 = 1'b0;
        forever begin
            @(negedge clk);
            ce_5m3 = ~ce_5m3;
            if (ce_5m3 && play && busy) wave.push_back(cas_out);
        end
    end

    // Buffer model with configurable read latency.
    initial begin
        int cur_dly;
        int wait_c;
        int r;
        ram_ready = 1'b0;
        ram_di = 8'h00;
        cur_dly = -1;
        wait_c = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ram_ready = 1'b0;
                cur_dly = -1;
                wait_c = 0;
                addr_bad = 0;
                rd_cnt = 0;
            end else if (ram_ready) begin
                ram_ready = 1'b0;
            end else if (inject_ready) begin
                ram_di = 8'hEE;
                ram_ready = 1'b1;
            end else if (ram_rd && !mem_hold) begin
                if (cur_dly < 0) begin
                    case (dly_mode)
                        0: cur_dly = 0;
                        2: cur_dly = 37;
                        default: begin
                            r = $urandom_range(0, 2);
                            cur_dly = (r == 0) ? 0 : ((r == 1) ? 1 : 37);
                        end
                    endcase
                    wait_c = 0;
                end
                if (wait_c >= cur_dly) begin
                    if (ram_a >= cas_size) addr_bad++;
                    rd_cnt++;
                    ram_di = mem[ram_a[5:0]];
                    ram_ready = 1'b1;
                    cur_dly = -1;
                end else begin
                    wait_c++;
                end
            end
        end
    end

    task automatic push_n(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_bit(input logic v);
        if (v) begin
            push_n(1'b1, H24); push_n(1'b0, H24);
            push_n(1'b1, H24); push_n(1'b0, H24);
        end else begin
            push_n(1'b1, H12); push_n(1'b0, H12);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(b[i]);
        push_bit(1'b1);
        push_bit(1'b1);
    endtask

    task automatic build_expected(input int n);
        int   gp;
        int   nv;
        int   cyc;
        logic is_sync;
        logic [7:0] pk;
        exp_q.delete();
        gp = 0;
        while (gp < n) begin
            nv = (n - gp >= 8) ? 8 : n - gp;
            is_sync = (nv == 8);
            for (int k = 0; k < nv; k++) if (mem[gp + k] !== sync_pat[k]) is_sync = 1'b0;
            if (is_sync) begin
                pk = (gp + 8 < n) ? mem[gp + 8] : 8'h00;
                if (pk == 8'hD3 || pk == 8'hEA || pk == 8'hD0) begin
`ifdef CAS_SILENCE_EN
                    push_n(1'b0, SIL);
`endif
                    cyc = LH;
                end else begin
                    cyc = SH;
                end
                for (int c = 0; c < cyc; c++) begin
                    push_n(1'b1, H24); push_n(1'b0, H24);
                end
            end else begin
                for (int k = 0; k < nv; k++) push_frame(mem[gp + k]);
            end
            gp += 8;
        end
    endtask

    function automatic int rises(input int from, input int to);
        int cnt = 0;
        for (int i = from; i < to; i++) begin
            if (wave_base + i < wave.size() && wave[wave_base + i] == 1'b1 &&
                (i == 0 || wave[wave_base + i - 1] == 1'b0)) cnt++;
        end
        return cnt;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; play = 1'b0; rewind = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic start_image(input int n, input int mode);
        cas_size = 27'(n);
        dly_mode = mode;
        build_expected(n);
        do_reset();
        wave_base = wave.size();
        play = 1'b1;
    endtask

    task automatic finish_image(input string tag);
        int cyc = 0;
        int mism = 0;
        int len;
        while (!eof && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_eof"}, eof, 1);
        check_val({tag, "_cas_low"}, cas_out, 0);
        check_val({tag, "_busy"}, busy, 0);
        len = wave.size() - wave_base;
        check_val({tag, "_len"}, len, exp_q.size());
        for (int i = 0; i < len && i < exp_q.size(); i++)
            if (wave[wave_base + i] !== exp_q[i]) mism++;
        check_val({tag, "_wave_mism"}, mism, 0);
    endtask

    initial begin
        int hdr_end;
        int cyc;
        int sz0;
        int changes;
        logic c0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rst_ram_a", ram_a, 0);
        check_val("rst_ram_rd", ram_rd, 0);
        check_val("rst_cas_out", cas_out, 0);
        check_val("rst_eof", eof, 0);
        check_val("rst_busy", busy, 0);

        // Empty image: eof two cycles after reset, no reads
        cas_size = 27'd0;
        do_reset();
        play = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("empty_eof", eof, 1);
        repeat (20) @(posedge clk);
        #1;
        check_val("empty_reads", rd_cnt, 0);

        // Eight 0x55 bytes, no sync
        for (int i = 0; i < 8; i++) mem[i] = 8'h55;
        start_image(8, 0);
        finish_image("b55");
        check_val("b55_frame0_rises", rises(0, 88), 17);
        check_val("b55_total_rises", rises(0, 8 * 88), 136);

        // Sync group followed by D3: long header then 24 data frames
        for (int i = 0; i < 8; i++) mem[i] = sync_pat[i];
        for (int i = 8; i < 32; i++) mem[i] = 8'hD3;
`ifdef CAS_SILENCE_EN
        hdr_end = SIL + LH * 2 * H24;
`else
        hdr_end = LH * 2 * H24;
`endif
        start_image(32, 0);
        finish_image("long");
        check_val("long_hdr_rises", rises(0, hdr_end), LH);
        check_val("long_data_start", wave[wave_base + hdr_end], 1);

        // Same image with random and long read latencies
        start_image(32, 1);
        finish_image("dly_rand");
        start_image(32, 2);
        finish_image("dly37");

        // Two sync groups: short header (lead 1F) then long header (lead D3)
        for (int i = 0; i < 8; i++) begin
            mem[i] = sync_pat[i];
            mem[i + 8] = sync_pat[i];
            mem[i + 16] = 8'hD3;
        end
        start_image(24, 0);
        finish_image("two_hdr");

        // Three-byte image with a 1000-cycle pause mid-bit of 0x80
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h80;
        start_image(3, 0);
        cyc = 0;
        while ((wave.size() - wave_base) < 203 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("pause_reached", (wave.size() - wave_base) >= 203, 1);
        play = 1'b0;
        c0 = cas_out;
        sz0 = wave.size();
        changes = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (cas_out !== c0) changes++;
        end
        check_val("pause_frozen", changes, 0);
        check_val("pause_no_adv", wave.size(), sz0);
        play = 1'b1;
        finish_image("size3");
        check_val("size3_bad_addr", addr_bad, 0);
        check_val("size3_reads", rd_cnt, 3);

        // Rewind with the gp=16 read pending, then a stray ready
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
        start_image(32, 0);
        cyc = 0;
        while (!(ram_rd && ram_a == 27'd16) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("rew_rd16_seen", ram_rd && ram_a == 27'd16, 1);
        mem_hold = 1'b1;
        rewind = 1'b1;
        @(posedge clk); #1;
        rewind = 1'b0;
        wave_base = wave.size();
        check_val("rew_rd_low", ram_rd, 0);
        check_val("rew_eof", eof, 0);
        check_val("rew_busy", busy, 0);
        inject_ready = 1'b1;
        @(posedge clk); #1;
        inject_ready = 1'b0;
        mem_hold = 1'b0;
        cyc = 0;
        while (!ram_rd && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("rew_next_rd", ram_rd, 1);
        check_val("rew_next_addr", ram_a, 0);
        finish_image("rew");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cas_fsk_player.md
Name: cas_fsk_player

Overview:
- Replaces the plain CAS bit source between the DDRAM cassette buffer and the MSX1 cassette input (cas_audio_in, File mode).
- Fetches CAS image bytes from the buffer over a rd/ready handshake.
- Detects 8-byte-aligned CAS header sync blocks and emits the MSX header tone in their place.
- Encodes all other bytes as 1200-baud MSX FSK square wave on cas_out; paced by ce_5m3 and gated by the cassette motor (play).

Parameters:
- HALF_1200, 2238, ce_5m3 ticks per half-period of a 1200 Hz cycle.
- HALF_2400, 1119, ce_5m3 ticks per half-period of a 2400 Hz cycle.
- LONG_HDR, 16000, 2400 Hz cycles in a long header.
- SHORT_HDR, 4000, 2400 Hz cycles in a short header.
- SILENCE_TICKS, 5369318, ce_5m3 ticks of silence before a long header (about 1 s; used only with the optional feature).

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- ce_5m3  in  1  clock enable, 5.369 MHz; all timing counters advance only on ce_5m3.
- play  in  1  1 = motor on, playback advances; 0 = pause.
- rewind  in  1  synchronous return to file start.
- cas_size  in  27  number of valid bytes in the buffer.
- ram_a  out  27  buffer byte address.
- ram_rd  out  1  read request.
- ram_di  in  8  read data.
- ram_ready  in  1  read complete; ram_di valid in the same cycle.
- cas_out  out  1  FSK audio bit to the MSX cassette input.
- eof  out  1  end of image reached.
- busy  out  1  high while emitting silence, header or data.

Behaviour:
- Clock/reset: single clock clk. reset is synchronous and active-high.
- Reset state: ram_a=0, ram_rd=0, cas_out=0, eof=0, busy=0, state=IDLE, group pointer gp=0.
- rewind: same effect as reset, but only on the position/state registers. Takes priority over every state, including a pending read; a ram_ready arriving afterwards is ignored.
- Read handshake:
  - Raise ram_rd with ram_a stable; hold both until ram_ready=1 is sampled.
  - Capture ram_di in that cycle; drop ram_rd the next cycle.
  - Only one outstanding read at a time. Reads are not gated by ce_5m3.
- States:
  - IDLE: if play=1 and gp<cas_size, go to FETCH; if gp>=cas_size, set eof=1 and stay.
  - FETCH: read bytes gp..gp+7 into an 8-byte group buffer. Bytes at addresses >= cas_size are not read and marked invalid. Then go to CHECK.
  - CHECK:
    - Group is a full valid match of 1F A6 DE BA CC 13 7D 74: go to PEEK.
    - Otherwise: go to DATA.
  - PEEK: read the byte at gp+8 (skip if >= cas_size, treat as 00).
    - Byte in {D3, EA, D0}: long header; with CAS_SILENCE_EN, enter SILENCE first.
    - Otherwise: short header.
  - SILENCE: cas_out=0 for SILENCE_TICKS ce ticks, then HEADER.
  - HEADER: emit LONG_HDR or SHORT_HDR cycles of 2400 Hz (high HALF_2400, then low HALF_2400). Then gp+=8, go to IDLE.
  - DATA:
    - Emit each valid group byte in order as an 11-bit frame: start bit 0, d0..d7 LSB first, two stop bits 1.
    - Bit 0 = one 1200 Hz cycle. Bit 1 = two 2400 Hz cycles. Each cycle is high then low.
    - After the last valid byte: gp+=8, go to IDLE.
- Bit timing: bit 0 and bit 1 both last 4*HALF_2400 = 2*HALF_1200 = 4476 ticks.
- Pause: play=0 freezes all tick counters, the bit index and cas_out. Fetch states finish their current read and then wait. play=1 resumes from the exact tick.
- busy=1 in SILENCE, HEADER and DATA.
- eof: set when IDLE sees gp>=cas_size, with cas_out=0. Cleared only by reset or rewind.
- cas_size=0: eof=1 two cycles after reset; no reads are issued.
- Widths: gp is 27 bits; gp+8 wraps modulo 2^27. A gp+8 >= cas_size comparison always ends playback.
- A sync group followed by another sync group produces two headers in sequence (short or long as each PEEK decides).

Optional Feature:
- Macro: CAS_SILENCE_EN.
- Defined: SILENCE state is inserted before every long header, with cas_out=0 for SILENCE_TICKS.
- Undefined: the long header starts directly after PEEK, and SILENCE_TICKS is unused.

Test Plan:
- Image 1F A6 DE BA CC 13 7D 74 D3 D3…, cas_size=32, play=1 -> exactly 16000 cas_out rising edges at 2238-tick period before the first data edge. With CAS_SILENCE_EN, 5369318 low ticks precede them.
- Image of 8 bytes 55 (no sync) -> first frame is 0,1,0,1,0,1,0,1,0,1,1 at 4476 ticks per bit. Bit 0 shows 1 rising edge, bit 1 shows 2. Then eof=1, cas_out=0.
- cas_size=3, bytes 00 FF 80 -> exactly 3 frames emitted; ram_rd never asserted with ram_a>=3; eof=1.
- play dropped for 1000 cycles mid-bit of byte 0x80 -> cas_out frozen; resumed waveform equals the uninterrupted waveform shifted by the pause length.
- rewind pulsed during DATA at gp=16, with a read pending -> next ram_rd has ram_a=0; the late ram_ready is ignored; eof=0.
- ram_ready delayed 0, 1 and 37 cycles on random reads -> cas_out waveform identical in all three cases.
